lsu_riscv: RTL and testbench
============================

# lsu_riscv

Load-store unit between the execute stage and the data memory port. Consumes the decoder's memory controls (request, write enable, access size) plus the ALU-computed address and the rs2 store data. Runs a request/grant/response handshake with data memory, formats byte/half/word data in both directions, and asserts `lsu_stall_req_o` so the decoder freezes the PC until the access completes.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk_i` in 1: core clock.
- `arstn_i` in 1: asynchronous, active-low reset.
- `lsu_req_i` in 1: memory access requested (decoder `mem_req_o`).
- `lsu_we_i` in 1: 1 = store, 0 = load (decoder `mem_we_o`).
- `lsu_size_i` in 3: access size, `LDST_B/H/W/BU/HU` encodings (decoder `mem_size_o`).
- `lsu_addr_i` in 32: byte address (ALU result).
- `lsu_data_i` in 32: store data (rs2).
- `lsu_data_o` out 32: formatted load result for write-back.
- `lsu_stall_req_o` out 1: core must hold PC and instruction.
- `lsu_misaligned_o` out 1: misaligned access detected, no memory access issued.
- `data_req_o` out 1: memory request.
- `data_we_o` out 1: memory write enable.
- `data_be_o` out 4: byte enables.
- `data_addr_o` out 32: word-aligned address, `{lsu_addr_i[31:2],2'b00}`.
- `data_wdata_o` out 32: replicated store data.
- `data_gnt_i` in 1: memory accepted request.
- `data_rvalid_i` in 1: response valid (read data, or write acknowledge).
- `data_rdata_i` in 32: read data word.

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID. Reset state: IDLE.
- IDLE:
  - `lsu_req_i=1` and aligned: `data_req_o=1` combinationally.
  - Capture we, size and `addr[1:0]` into registers.
  - `data_gnt_i=1` in the same cycle goes to WAIT_RVALID; otherwise go to WAIT_GNT.
- WAIT_GNT: `data_req_o=1` with the captured controls; move to WAIT_RVALID on `data_gnt_i`.
- WAIT_RVALID: `data_req_o=0`; return to IDLE on `data_rvalid_i`.
- Stall:
  - IDLE: `lsu_stall_req_o = lsu_req_i & ~misaligned`.
  - WAIT_GNT: 1.
  - WAIT_RVALID: `~data_rvalid_i`.
  - Result: stall drops in the response cycle, the PC advances, and the request is not reissued.
- Misalignment:
  - H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`.
  - `lsu_misaligned_o=1` for that cycle, no request, no stall, FSM stays IDLE.
- Unsupported size codes (011, 110, 111) are handled as W.
- Store formatting:
  - B: `be = 4'b0001<<addr[1:0]`, `wdata = {4{data[7:0]}}`.
  - H: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{data[15:0]}}`.
  - W: `be = 4'b1111`, `wdata = data`.
- For loads, `data_be_o` uses the same mask; `data_we_o=0`.
- Load formatting from the captured offset and size:
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Lane selected by `addr[1:0]` for bytes, `addr[1]` for halves.
- `lsu_data_o` is valid only in the cycle `data_rvalid_i=1` in WAIT_RVALID, for a load. In every other cycle, and for stores, it is 0.

## Timing
- Reset values: all outputs 0 and the FSM in IDLE. Capture registers reset to 0.
- Best-case latency: request in cycle N, gnt in N, rvalid in N+1. Stall is high in N and low in N+1, where load data is valid.
- Memory contract: rvalid arrives at least 1 cycle after gnt. Any rvalid outside WAIT_RVALID is ignored.
- Gnt outside IDLE/WAIT_GNT is ignored.
- The core holds `lsu_*` inputs stable while stalled. The LSU still uses its captured copies in WAIT states.
- Reset asserted mid-access: the FSM returns to IDLE and `data_req_o` drops immediately (asynchronous). A late rvalid after reset release is ignored.
- `lsu_req_i` deasserted in WAIT states (stall not honoured) does not abort the access. The FSM completes the handshake.

## Structure
- The FSM state enum typedef (`lsu_state_t`) goes in the shared RISC-V package.
- LDST size encodings stay in the shared defines already used by the decoder.
- One sub-module: `lsu_data_align`, purely combinational. It produces be/wdata for stores and the extended load result from (size, offset, data).
- The FSM and capture registers stay in `lsu_riscv`.

## Test plan
- LW at 0x100, gnt same cycle, rdata=0xDEADBEEF next cycle:
  - `data_addr_o=0x100`, `be=1111`.
  - Stall 1 then 0.
  - `lsu_data_o=0xDEADBEEF` in the rvalid cycle.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF_0000:
  - LB: `lsu_data_o=0xFFFFFF80`.
  - LBU: `lsu_data_o=0x00000080`.
- SH at 0x202 with data 0x1234ABCD, gnt delayed 3 cycles:
  - `data_req_o` held for 4 cycles.
  - `be=1100`, `wdata=0xABCDABCD`, `addr=0x200`.
  - Stall stays high until the rvalid cycle.
- LW at 0x101:
  - `lsu_misaligned_o=1` for 1 cycle.
  - `data_req_o=0`, stall 0, FSM remains IDLE.
- Reset pulse in WAIT_RVALID, then stray rvalid:
  - All outputs 0 immediately.
  - Stray rvalid ignored.
  - Next LW completes normally.
- Back-to-back SB at 0x001 (data 0x55) then LHU at 0x002 (rdata=0x8001_0000):
  - SB: `be=0010`, `wdata=0x55555555`.
  - LHU: `lsu_data_o=0x00008001`.
  - Exactly one request per instruction.

Source files
------------

// File: rtl/lsu_riscv_pkg.sv
// Shared RISC-V definitions used by the decoder and the load-store unit.
// Holds the load/store size encodings, the LSU state type and the alignment check.
package lsu_riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_GNT    = 2'd1,
        ST_WAIT_RVALID = 2'd2
    } lsu_state_t;

    // Size codes outside B/H/BU/HU are treated as word accesses.
    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: lsu_misaligned = 1'b0;
            LDST_H, LDST_HU: lsu_misaligned = off[0];
            default:         lsu_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_riscv_if.sv
// Data memory port: request/grant/response handshake between the LSU and memory.
interface lsu_riscv_if;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/lsu_riscv_data_align.sv
// Combinational byte/half/word formatting: store lanes and byte enables, load extension.
module lsu_data_align
    import lsu_riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (size)
            LDST_B, LDST_BU: begin
                be    = 4'b0001 << off;
                wdata = {4{st_data[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (off)
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ;
        endcase
        ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        case (size)
            LDST_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            LDST_BU: ld_data = {24'h0, ld_byte};
            LDST_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            LDST_HU: ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end
endmodule

// File: rtl/lsu_riscv.sv
// Load-store unit: drives the data memory handshake and stalls the core until
// the access completes. Misaligned accesses are flagged and never issued.
module lsu_riscv
    import lsu_riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misaligned_o,
    lsu_riscv_if.master dmem
);
    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;

    logic        is_idle, mis, start, req;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic [1:0]  sel_off;
    logic [3:0]  be_w;
    logic [31:0] wdata_w, ld_w;

    assign is_idle = (state_q == ST_IDLE);
    assign mis     = lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);
    assign start   = is_idle & lsu_req_i & ~mis;

    // Live controls in IDLE, captured copies once the access is in flight.
    assign sel_we   = is_idle ? lsu_we_i          : we_q;
    assign sel_size = is_idle ? lsu_size_i        : size_q;
    assign sel_off  = is_idle ? lsu_addr_i[1:0]   : off_q;

    lsu_data_align u_align (
        .size    (sel_size),
        .off     (sel_off),
        .st_data (lsu_data_i),
        .ld_word (dmem.data_rdata_i),
        .be      (be_w),
        .wdata   (wdata_w),
        .ld_data (ld_w)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (start) state_d = dmem.data_gnt_i ? ST_WAIT_RVALID : ST_WAIT_GNT;
            ST_WAIT_GNT:    if (dmem.data_gnt_i) state_d = ST_WAIT_RVALID;
            ST_WAIT_RVALID: if (dmem.data_rvalid_i) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (start) begin
                we_q   <= lsu_we_i;
                size_q <= lsu_size_i;
                off_q  <= lsu_addr_i[1:0];
            end
        end
    end

    // Gating with arstn_i lets the bus and stall drop the moment reset asserts.
    assign req = arstn_i & (start | (state_q == ST_WAIT_GNT));

    assign dmem.data_req_o   = req;
    assign dmem.data_we_o    = req & sel_we;
    assign dmem.data_be_o    = req ? be_w : 4'b0000;
    assign dmem.data_addr_o  = req ? {lsu_addr_i[31:2], 2'b00} : 32'h0;
    assign dmem.data_wdata_o = req ? wdata_w : 32'h0;

    always_comb begin
        lsu_stall_req_o = 1'b0;
        case (state_q)
            ST_IDLE:        lsu_stall_req_o = start;
            ST_WAIT_GNT:    lsu_stall_req_o = 1'b1;
            ST_WAIT_RVALID: lsu_stall_req_o = ~dmem.data_rvalid_i;
            default:        lsu_stall_req_o = 1'b0;
        endcase
        lsu_stall_req_o = lsu_stall_req_o & arstn_i;
    end

    assign lsu_misaligned_o = arstn_i & is_idle & lsu_req_i & mis;

    assign lsu_data_o = ((state_q == ST_WAIT_RVALID) & dmem.data_rvalid_i & ~we_q) ? ld_w : 32'h0;
endmodule

// File: tb/tb_lsu_riscv.sv
// Directed self-checking bench for lsu_riscv; the bench plays the data memory.
module tb_lsu_riscv;
    import lsu_riscv_pkg::*;

    logic        clk = 1'b0;
    logic        arstn;
    logic        lsu_req, lsu_we;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_data;
    logic [31:0] lsu_data_o;
    logic        stall, misaligned;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          acc_cnt  = 0;
    int          acc_base;

    lsu_riscv_if dmem ();

    lsu_riscv dut (
        .clk_i            (clk),
        .arstn_i          (arstn),
        .lsu_req_i        (lsu_req),
        .lsu_we_i         (lsu_we),
        .lsu_size_i       (lsu_size),
        .lsu_addr_i       (lsu_addr),
        .lsu_data_i       (lsu_data),
        .lsu_data_o       (lsu_data_o),
        .lsu_stall_req_o  (stall),
        .lsu_misaligned_o (misaligned),
        .dmem             (dmem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dmem.data_req_o && dmem.data_gnt_i) acc_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic mem(input logic gnt, input logic rv, input logic [31:0] rd);
        dmem.data_gnt_i    = gnt;
        dmem.data_rvalid_i = rv;
        dmem.data_rdata_i  = rd;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        lsu_req  = req;
        lsu_we   = we;
        lsu_size = sz;
        lsu_addr = a;
        lsu_data = d;
    endtask

    // Load with grant in the request cycle and response one cycle later.
    task automatic do_load(input string tag, input logic [2:0] sz, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] rd, input logic [31:0] exp);
        step(); cpu(1, 0, sz, a, 32'h0); mem(1, 0, 32'h0); #1;
        chk({tag, "_req"},   {31'h0, dmem.data_req_o}, 32'd1);
        chk({tag, "_we"},    {31'h0, dmem.data_we_o}, 32'd0);
        chk({tag, "_addr"},  dmem.data_addr_o, {a[31:2], 2'b00});
        chk({tag, "_be"},    {28'h0, dmem.data_be_o}, {28'h0, be});
        chk({tag, "_stall1"}, {31'h0, stall}, 32'd1);
        step(); mem(0, 1, rd); #1;
        chk({tag, "_stall0"}, {31'h0, stall}, 32'd0);
        chk({tag, "_req0"},  {31'h0, dmem.data_req_o}, 32'd0);
        chk({tag, "_data"},  lsu_data_o, exp);
        step(); cpu(0, 0, 3'b0, 32'h0, 32'h0); mem(0, 0, 32'h0); #1;
        chk({tag, "_data_idle"}, lsu_data_o, 32'h0);
    endtask

    initial begin
        arstn = 1'b0;
        cpu(0, 0, 3'b0, 32'h0, 32'h0);
        mem(0, 0, 32'h0);
        #12;
        chk("rst_req",   {31'h0, dmem.data_req_o}, 32'd0);
        chk("rst_stall", {31'h0, stall}, 32'd0);
        chk("rst_be",    {28'h0, dmem.data_be_o}, 32'd0);
        chk("rst_data",  lsu_data_o, 32'h0);
        step(); arstn = 1'b1;

        do_load("lw100",  LDST_W,  32'h100, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb103",  LDST_B,  32'h103, 4'b1000, 32'h80FF0000, 32'hFFFFFF80);
        do_load("lbu103", LDST_BU, 32'h103, 4'b1000, 32'h80FF0000, 32'h00000080);

        // SH at 0x202, grant withheld for three cycles
        step(); cpu(1, 1, LDST_H, 32'h202, 32'h1234ABCD); mem(0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem(1, 0, 32'h0);
            #1;
            chk($sformatf("sh_req%0d", i),   {31'h0, dmem.data_req_o}, 32'd1);
            chk($sformatf("sh_we%0d", i),    {31'h0, dmem.data_we_o}, 32'd1);
            chk($sformatf("sh_be%0d", i),    {28'h0, dmem.data_be_o}, 32'hC);
            chk($sformatf("sh_wdata%0d", i), dmem.data_wdata_o, 32'hABCDABCD);
            chk($sformatf("sh_addr%0d", i),  dmem.data_addr_o, 32'h200);
            chk($sformatf("sh_stall%0d", i), {31'h0, stall}, 32'd1);
            step();
        end
        mem(0, 0, 32'h0); #1;
        chk("sh_wr_req0",  {31'h0, dmem.data_req_o}, 32'd0);
        chk("sh_wr_stall", {31'h0, stall}, 32'd1);
        step(); mem(0, 1, 32'h0); #1;
        chk("sh_ack_stall", {31'h0, stall}, 32'd0);
        chk("sh_ack_data",  lsu_data_o, 32'h0);
        step(); cpu(0, 0, 3'b0, 32'h0, 32'h0); mem(0, 0, 32'h0); #1;
        chk("sh_done_req", {31'h0, dmem.data_req_o}, 32'd0);

        // Misaligned word load
        step(); cpu(1, 0, LDST_W, 32'h101, 32'h0); #1;
        chk("mis_flag",  {31'h0, misaligned}, 32'd1);
        chk("mis_req",   {31'h0, dmem.data_req_o}, 32'd0);
        chk("mis_stall", {31'h0, stall}, 32'd0);
        step(); cpu(0, 0, 3'b0, 32'h0, 32'h0); #1;
        chk("mis_clear", {31'h0, misaligned}, 32'd0);

        // Reset in WAIT_RVALID, then a stray response
        step(); cpu(1, 0, LDST_W, 32'h300, 32'h0); mem(1, 0, 32'h0); #1;
        chk("rstmid_req", {31'h0, dmem.data_req_o}, 32'd1);
        step(); mem(0, 0, 32'h0); #1;
        chk("rstmid_wait_stall", {31'h0, stall}, 32'd1);
        arstn = 1'b0; #1;
        chk("rstmid_req0",   {31'h0, dmem.data_req_o}, 32'd0);
        chk("rstmid_stall0", {31'h0, stall}, 32'd0);
        chk("rstmid_be0",    {28'h0, dmem.data_be_o}, 32'd0);
        step(); arstn = 1'b1; cpu(0, 0, 3'b0, 32'h0, 32'h0);
        step(); mem(0, 1, 32'hCAFEF00D); #1;
        chk("stray_data",  lsu_data_o, 32'h0);
        chk("stray_stall", {31'h0, stall}, 32'd0);
        step(); mem(0, 0, 32'h0);
        do_load("lw_after_rst", LDST_W, 32'h104, 4'b1111, 32'h01234567, 32'h01234567);

        // Back-to-back SB then LHU
        acc_base = acc_cnt;
        step(); cpu(1, 1, LDST_B, 32'h001, 32'h00000055); mem(1, 0, 32'h0); #1;
        chk("sb_be",    {28'h0, dmem.data_be_o}, 32'h2);
        chk("sb_wdata", dmem.data_wdata_o, 32'h55555555);
        chk("sb_addr",  dmem.data_addr_o, 32'h0);
        chk("sb_we",    {31'h0, dmem.data_we_o}, 32'd1);
        step(); mem(0, 1, 32'h0); #1;
        chk("sb_stall0", {31'h0, stall}, 32'd0);
        chk("sb_req0",   {31'h0, dmem.data_req_o}, 32'd0);
        step(); cpu(1, 0, LDST_HU, 32'h002, 32'h0); mem(1, 0, 32'h0); #1;
        chk("lhu_be",  {28'h0, dmem.data_be_o}, 32'hC);
        chk("lhu_req", {31'h0, dmem.data_req_o}, 32'd1);
        step(); mem(0, 1, 32'h80010000); #1;
        chk("lhu_data", lsu_data_o, 32'h00008001);
        step(); cpu(0, 0, 3'b0, 32'h0, 32'h0); mem(0, 0, 32'h0); #1;
        step();
        chk("b2b_accesses", acc_cnt - acc_base, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
